// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the instruction-memory writer and the
// fetch stage: instruction codes, instruction-memory size and the
// icode -> {legal, length} rule.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam int unsigned IMEM_DEPTH = 1024;

    // Returns {legal, len[3:0]}; len is 0 for illegal codes (C..F).
    function automatic logic [4:0] instr_len(input logic [3:0] icode);
        logic [4:0] r;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RET:                  r = {1'b1, 4'd1};
            ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:  r = {1'b1, 4'd2};
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:          r = {1'b1, 4'd10};
            ICODE_JXX, ICODE_CALL:                             r = {1'b1, 4'd9};
            default:                                           r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational instruction-length decoder.
//   icode  in   4  instruction code
//   legal  out  1  icode is a defined Y86-64 instruction
//   len    out  4  encoded length in bytes (0 when illegal)
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       legal,
    output logic [3:0] len
);

    assign {legal, len} = instr_len(icode);

endmodule

// File: rtl/y86_imem_writer.sv
// Y86-64 instruction encoder/loader. Accepts one decoded instruction per
// handshake, serialises it into the byte image fetch parses, and writes it
// one byte per cycle into instruction memory at an auto-incrementing pointer.
//   clk, reset          clock, synchronous active-high reset
//   addr_load, addr_in  load the write pointer (IDLE only)
//   in_valid, in_ready  instruction handshake
//   icode, ifun, rA, rB, valC  decoded instruction fields
//   mem_we, mem_addr, mem_wdata  byte write port
//   wr_ptr              next free address
//   busy                high while emitting bytes
//   enc_error           1-cycle pulse: illegal icode rejected
//   ovf_error           1-cycle pulse: instruction would not fit
module y86_imem_writer
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MEM_DEPTH = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy,
    output logic              enc_error,
    output logic              ovf_error
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;
    localparam int unsigned PW = ADDR_W + 1;

    logic              state;
    logic              dec_legal;
    logic [3:0]        dec_len;
    logic              accept;
    logic [PW-1:0]     end_ext;
    logic              fits;

    logic [3:0]        lat_icode, lat_ifun, lat_ra, lat_rb;
    logic [63:0]       lat_valc;
    logic [3:0]        lat_len;
    logic [ADDR_W-1:0] start_addr;
    logic [3:0]        idx;

    logic              has_regs;
    logic [2:0]        vidx;
    logic [7:0]        byte_sel;

    y86_instr_len u_len (
        .icode (icode),
        .legal (dec_legal),
        .len   (dec_len)
    );

    assign in_ready = (state == ST_IDLE) && !addr_load;
    assign accept   = in_valid && in_ready;

    // One extra bit so an instruction ending exactly at MEM_DEPTH still fits.
    assign end_ext = {1'b0, wr_ptr} + PW'(dec_len);
    assign fits    = end_ext <= PW'(MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            idx        <= '0;
            start_addr <= '0;
            lat_icode  <= '0;
            lat_ifun   <= '0;
            lat_ra     <= '0;
            lat_rb     <= '0;
            lat_valc   <= '0;
            lat_len    <= '0;
            enc_error  <= 1'b0;
            ovf_error  <= 1'b0;
        end else begin
            enc_error <= 1'b0;
            ovf_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (addr_load) begin
                        wr_ptr <= addr_in;
                    end else if (accept) begin
                        if (!dec_legal) begin
                            enc_error <= 1'b1;
                        end else if (!fits) begin
                            ovf_error <= 1'b1;
                        end else begin
                            lat_icode  <= icode;
                            lat_ifun   <= ifun;
                            lat_ra     <= rA;
                            lat_rb     <= rB;
                            lat_valc   <= valC;
                            lat_len    <= dec_len;
                            start_addr <= wr_ptr;
                            idx        <= '0;
                            state      <= ST_EMIT;
                        end
                    end
                end
                default: begin
                    if (idx == 4'(lat_len - 4'd1)) begin
                        state  <= ST_IDLE;
                        idx    <= '0;
                        // Truncation wraps the pointer to 0 at end of memory.
                        wr_ptr <= start_addr + ADDR_W'(lat_len);
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
            endcase
        end
    end

    // Byte select: opcode, then optional register byte, then valC little-endian.
    always_comb begin
        has_regs = (lat_len == 4'd2) || (lat_len == 4'd10);
        vidx     = has_regs ? 3'(idx - 4'd2) : 3'(idx - 4'd1);
        byte_sel = '0;
        if (idx == 4'd0)
            byte_sel = {lat_icode, lat_ifun};
        else if (has_regs && idx == 4'd1)
            byte_sel = {lat_ra, lat_rb};
        else
            byte_sel = lat_valc[{vidx, 3'b000} +: 8];
    end

    assign busy      = (state == ST_EMIT);
    assign mem_we    = busy;
    assign mem_addr  = busy ? start_addr + ADDR_W'(idx) : '0;
    assign mem_wdata = busy ? byte_sel : '0;

endmodule

// File: tb/tb_y86_imem_writer.sv
// Self-checking bench for y86_imem_writer: directed cases plus randomized
// instructions checked against a byte-image reference model.
module tb_y86_imem_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        addr_load;
    logic [9:0]  addr_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [9:0]  wr_ptr;
    logic        busy, enc_error, ovf_error;

    int n_checks = 0;
    int n_errors = 0;
    int ref_ptr  = 0;

    always #5 clk = ~clk;

    y86_imem_writer #(.ADDR_W(10), .MEM_DEPTH(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_load (addr_load),
        .addr_in   (addr_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .wr_ptr    (wr_ptr),
        .busy      (busy),
        .enc_error (enc_error),
        .ovf_error (ovf_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 0;
        endcase
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (in_ready) return;
            step();
        end
        check("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic scramble();
        icode = 4'($urandom); ifun = 4'($urandom);
        rA = 4'($urandom); rB = 4'($urandom);
        valC = {$urandom, $urandom};
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
        logic [7:0] img[$];
        int         len;
        logic [9:0] a;
        len = ref_len(ic);
        img = {};
        img.push_back({ic, fn});
        if (len == 2 || len == 10) img.push_back({ra, rb});
        if (len >= 9)
            for (int k = 0; k < 8; k++) img.push_back(8'(vc >> (8 * k)));

        wait_ready();
        in_valid = 1'b1; icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
        step();
        in_valid = 1'b0;
        scramble();

        if (len == 0) begin
            check("enc_pulse", {61'd0, enc_error, ovf_error, mem_we}, 64'b100);
            check("enc_ptr", 64'(wr_ptr), 64'(ref_ptr));
            step();
            check("enc_after", {61'd0, enc_error, in_ready, mem_we}, 64'b010);
        end else if (ref_ptr + len > 1024) begin
            check("ovf_pulse", {61'd0, enc_error, ovf_error, mem_we}, 64'b010);
            check("ovf_ptr", 64'(wr_ptr), 64'(ref_ptr));
            step();
            check("ovf_after", {61'd0, ovf_error, in_ready, mem_we}, 64'b010);
        end else begin
            for (int i = 0; i < len; i++) begin
                a = 10'(ref_ptr + i);
                check("byte", {44'd0, mem_we, busy, mem_addr, mem_wdata},
                      {44'd0, 1'b1, 1'b1, a, img[i]});
                if (i == 0)
                    check("ptr_hold", {61'd0, wr_ptr, in_ready, enc_error | ovf_error},
                          {61'd0, 10'(ref_ptr), 1'b0, 1'b0});
                step();
            end
            ref_ptr = (ref_ptr + len) % 1024;
            check("done", {61'd0, mem_we, busy, in_ready}, 64'b001);
            check("wr_ptr", 64'(wr_ptr), 64'(ref_ptr));
        end
    endtask

    task automatic load_ptr(input logic [9:0] a, input logic with_valid);
        wait_ready();
        addr_load = 1'b1; addr_in = a;
        if (with_valid) begin
            in_valid = 1'b1; icode = 4'h1; ifun = 4'h0;
        end
        #1;
        check("load_ready", 64'(in_ready), 64'd0);
        step();
        addr_load = 1'b0; in_valid = 1'b0;
        ref_ptr = int'(a);
        check("load_ptr", {52'd0, wr_ptr, mem_we, busy}, {52'd0, a, 1'b0, 1'b0});
        step();
        check("load_noacc", {62'd0, mem_we, in_ready}, 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; addr_load = 1'b0; addr_in = '0; in_valid = 1'b0;
        icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
        step(); step();
        check("reset_out", {38'd0, mem_we, busy, enc_error, ovf_error, mem_addr, mem_wdata, wr_ptr},
              64'd0);
        reset = 1'b0;
        #1;
        check("reset_ready", 64'(in_ready), 64'd1);

        // irmovq, back-to-back addq/halt, jXX at 0x20
        send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        reset = 1'b1; step(); reset = 1'b0; ref_ptr = 0;
        send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        load_ptr(10'h020, 1'b0);
        send(4'h7, 4'h3, 4'h0, 4'h0, 64'h40);

        // overflow, then call ending exactly at the last byte
        load_ptr(10'h3F8, 1'b0);
        send(4'h3, 4'h0, 4'hF, 4'h1, 64'h1122334455667788);
        load_ptr(10'h3F7, 1'b0);
        send(4'h8, 4'h0, 4'h5, 4'h5, 64'hCAFEF00D12345678);

        // illegal icode; load together with in_valid
        send(4'hC, 4'h0, 4'h1, 4'h2, 64'h0);
        load_ptr(10'h155, 1'b1);

        // reset in the middle of an irmovq
        wait_ready();
        in_valid = 1'b1; icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h2; valC = 64'hAA;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_emit", {62'd0, mem_we, busy}, 64'b11);
        reset = 1'b1;
        step();
        check("abort_out", {38'd0, mem_we, busy, enc_error, ovf_error, mem_addr, mem_wdata, wr_ptr},
              64'd0);
        reset = 1'b0;
        ref_ptr = 0;
        #1;
        check("abort_ready", 64'(in_ready), 64'd1);

        // randomized instructions against the reference model
        for (int n = 0; n < 60; n++) begin
            if (n % 8 == 7)
                load_ptr(($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(1012, 1023)), 1'b0);
            send(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                 {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
